// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory responder state encoding, default bus widths and bus-select codes.
package cpu_pkg;

   localparam int ADDR_W_DEF = 9;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } mem_state_e;

   // Internal bus source selects shared with the datapath muxes.
   localparam logic [1:0] BUS_SEL_ALU = 2'd0;
   localparam logic [1:0] BUS_SEL_MDR = 2'd1;
   localparam logic [1:0] BUS_SEL_PC  = 2'd2;
   localparam logic [1:0] BUS_SEL_RAM = 2'd3;

endpackage

// File: rtl/ram_sp.sv
// Single-port storage, synchronous write and registered read, no reset.
// Read output only updates on an enabled read, so it holds across writes.
module ram_sp #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-stated memory responder: fixed latency of WAIT_CYCLES+2 cycles from acceptance to done.
// Accepts one request only while IDLE; req_ready low for the whole WAIT/ACCESS/DONE sequence.
module mem_responder
   import cpu_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              req_ready,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              busy
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   mem_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              write_q;
   logic              rd_vld_q;
   logic [DATA_W-1:0] ram_rdata;
   logic              accept;
   logic              access;

   assign accept = req_valid && (state_q == ST_IDLE);
   assign access = (state_q == ST_ACCESS);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end else begin
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ACCESS: state_d = ST_DONE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            write_q <= req_write;
         end
         if (access && !write_q) begin
            rd_vld_q <= 1'b1;
         end
      end
   end

   // Storage is only enabled in ACCESS, so a reset before the exit edge leaves it untouched.
   ram_sp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .en_i    (access),
      .we_i    (write_q),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   // RAM output has no reset; mask it to zero until the first read after reset.
   assign rdata     = rd_vld_q ? ram_rdata : '0;
   assign req_ready = (state_q == ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder with WAIT_CYCLES=2 (unit 0) and WAIT_CYCLES=0 (unit 1) against an array model.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        clr;
   logic        v   [2];
   logic        w   [2];
   logic [8:0]  a   [2];
   logic [31:0] wd  [2];
   logic        rdy [2];
   logic        dn  [2];
   logic        bz  [2];
   logic [31:0] rd  [2];

   logic [31:0] mem_m  [2][512];
   bit          wr_m   [2][512];
   logic [31:0] exp_rd [2];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) dut_w2 (
      .clk(clk), .clr(clr), .req_valid(v[0]), .req_write(w[0]), .addr(a[0]), .wdata(wd[0]),
      .req_ready(rdy[0]), .done(dn[0]), .rdata(rd[0]), .busy(bz[0]));

   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .clr(clr), .req_valid(v[1]), .req_write(w[1]), .addr(a[1]), .wdata(wd[1]),
      .req_ready(rdy[1]), .done(dn[1]), .rdata(rd[1]), .busy(bz[1]));

   function automatic int lat_of(input int u);
      return (u == 0) ? 4 : 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // One complete transaction; inputs are scrambled right after acceptance.
   task automatic run_txn(input int u, input bit wr, input logic [8:0] ad, input logic [31:0] d);
      int n;
      int nb;
      bit seen;
      @(negedge clk);
      v[u] = 1'b1; w[u] = wr; a[u] = ad; wd[u] = d;
      check("ready_idle", 32'(rdy[u]), 32'd1);
      @(posedge clk);
      #1;
      v[u] = 1'b0; w[u] = 1'($urandom); a[u] = 9'($urandom); wd[u] = $urandom;
      n = 0; nb = 0; seen = 1'b0;
      while (!seen && n < 12) begin
         @(negedge clk);
         n++;
         if (bz[u]) nb++;
         if (dn[u]) seen = 1'b1;
         else check("rdata_hold", rd[u], exp_rd[u]);
      end
      check("done_seen", 32'(seen), 32'd1);
      check("latency", 32'(n), 32'(lat_of(u)));
      check("busy_cycles", 32'(nb), 32'(lat_of(u)));
      if (wr) begin
         mem_m[u][ad] = d;
         wr_m[u][ad]  = 1'b1;
      end else if (wr_m[u][ad]) begin
         exp_rd[u] = mem_m[u][ad];
      end
      check(wr ? "rdata_after_wr" : "rdata_read", rd[u], exp_rd[u]);
      @(negedge clk);
      check("done_pulse_end", 32'(dn[u]), 32'd0);
   endtask

   task automatic hold_test();
      int k;
      int done_k;
      int ready_k;
      logic [31:0] first_exp;
      @(negedge clk);
      v[0] = 1'b1; w[0] = 1'b0; a[0] = 9'h1FF;
      @(posedge clk);
      #1;
      a[0] = 9'h000;
      first_exp = mem_m[0][9'h1FF];
      k = 0; done_k = 0; ready_k = 0;
      while (ready_k == 0 && k < 20) begin
         @(negedge clk);
         k++;
         if (dn[0] && done_k == 0) begin
            done_k = k;
            check("hold_rdata_1ff", rd[0], first_exp);
            check("hold_ready_in_done", 32'(rdy[0]), 32'd0);
         end
         if (rdy[0]) ready_k = k;
      end
      check("hold_latency", 32'(done_k), 32'd4);
      check("hold_period", 32'(ready_k), 32'd5);
      @(posedge clk);
      #1;
      v[0] = 1'b0;
      k = 0; done_k = 0;
      while (done_k == 0 && k < 20) begin
         @(negedge clk);
         k++;
         if (dn[0]) done_k = k;
      end
      check("hold2_latency", 32'(done_k), 32'd4);
      exp_rd[0] = mem_m[0][9'h000];
      check("hold2_rdata_000", rd[0], exp_rd[0]);
      @(negedge clk);
   endtask

   task automatic reset_mid_wait();
      @(negedge clk);
      v[0] = 1'b1; w[0] = 1'b1; a[0] = 9'h010; wd[0] = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      v[0] = 1'b0;
      @(negedge clk);
      check("rst_in_wait_busy", 32'(bz[0]), 32'd1);
      #2 clr = 1'b0;
      #1;
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
      for (int u = 0; u < 2; u++) begin
         check("rst_busy", 32'(bz[u]), 32'd0);
         check("rst_done", 32'(dn[u]), 32'd0);
         check("rst_rdata", rd[u], 32'd0);
      end
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      check("rst_ready_first", 32'(rdy[0]), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rst_no_done", 32'(dn[0]), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int u = 0; u < 2; u++) begin
         v[u] = 1'b0; w[u] = 1'b0; a[u] = '0; wd[u] = '0; exp_rd[u] = '0;
      end
      clr = 1'b1;
      #2 clr = 1'b0;
      #1;
      for (int u = 0; u < 2; u++) begin
         check("reset_ready", 32'(rdy[u]), 32'd1);
         check("reset_busy", 32'(bz[u]), 32'd0);
         check("reset_done", 32'(dn[u]), 32'd0);
         check("reset_rdata", rd[u], 32'd0);
      end
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;

      run_txn(0, 1'b1, 9'h005, 32'hDEADBEEF);
      run_txn(0, 1'b0, 9'h005, 32'h0);
      run_txn(1, 1'b1, 9'h0A0, 32'h12345678);
      run_txn(1, 1'b0, 9'h0A0, 32'h0);

      run_txn(0, 1'b1, 9'h1FF, $urandom);
      run_txn(0, 1'b1, 9'h000, $urandom);
      hold_test();

      run_txn(0, 1'b1, 9'h010, 32'h11111111);
      reset_mid_wait();
      run_txn(0, 1'b0, 9'h010, 32'h0);

      for (int i = 0; i < 60; i++) begin
         int u;
         logic [8:0] ad;
         bit wr;
         u  = int'($urandom_range(0, 1));
         ad = ($urandom_range(0, 3) == 0) ? 9'(9'h1F0 + $urandom_range(0, 15)) : 9'($urandom_range(0, 15));
         wr = !wr_m[u][ad] || ($urandom_range(0, 1) == 1);
         run_txn(u, wr, ad, $urandom);
         if (wr && $urandom_range(0, 2) == 0) run_txn(u, 1'b0, ad, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
